// File: rtl/voice_mixer.sv
// voice_mixer: serial 8-voice multiply-accumulate mixer driving an R2R DAC.
// A sample strobe snapshots the voice buses. One voice per clock is then
// multiplied by its envelope and accumulated into a 27-bit sum. The scaled
// result is registered onto r2r_out nine clocks after the strobe.
// Optional build macro: MIXER_SATURATE_EN selects 2x gain with clipping at
// 255 in place of the default divide-by-8 average.
module voice_mixer #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned SAMPLE_W   = 32,
    parameter int unsigned ENV_W      = 8,
    parameter int unsigned OUT_W      = 8
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           sample_strobe,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic [NUM_VOICES*ENV_W-1:0]    envelopes,
    input  logic [NUM_VOICES-1:0]          voice_active,
    output logic [OUT_W-1:0]               r2r_out,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int unsigned AccW  = 27;
    localparam int unsigned SW    = 16;  // only the top half of each sample is mixed
    localparam int unsigned ProdW = SW + ENV_W;
    localparam int unsigned IdxW  = $clog2(NUM_VOICES);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]                       state_q, state_d;
    logic [NUM_VOICES-1:0][SW-1:0]    samp_q, samp_d;
    logic [NUM_VOICES-1:0][ENV_W-1:0] env_q, env_d;
    logic [NUM_VOICES-1:0]            act_q, act_d;
    logic [AccW-1:0]                  acc_q, acc_d;
    logic [IdxW-1:0]                  idx_q, idx_d;
    logic [OUT_W-1:0]                 r2r_q, r2r_d;
    logic                             valid_q, valid_d;
    logic                             overrun_q, overrun_d;
    logic [ProdW-1:0]                 prod;
    logic [OUT_W-1:0]                 mix;
    logic                             unused_sample_lsbs;

    // Low sample halves never reach the mix.
    always_comb begin
        unused_sample_lsbs = 1'b0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            unused_sample_lsbs = unused_sample_lsbs ^ (^voice_samples[i*SAMPLE_W +: SAMPLE_W-SW]);
        end
    end

    // Gated product of the voice currently selected by idx.
    always_comb begin
        prod = '0;
        if (act_q[idx_q]) begin
            prod = ProdW'(samp_q[idx_q]) * ProdW'(env_q[idx_q]);
        end
    end

    // Map the finished accumulator onto the DAC range.
    always_comb begin
`ifdef MIXER_SATURATE_EN
        if (acc_q[AccW-1]) begin
            mix = '1;
        end else begin
            mix = acc_q[AccW-2 -: OUT_W];
        end
`else
        mix = acc_q[AccW-1 -: OUT_W];
`endif
    end

    // Next-state logic: snapshot in IDLE, one voice per clock in ACCUM, publish in DONE.
    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        env_d     = env_q;
        act_d     = act_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        r2r_d     = r2r_q;
        valid_d   = 1'b0;
        // A strobe that finds the mixer busy is dropped, never queued.
        overrun_d = overrun_q | (sample_strobe && (state_q != StIdle));

        case (state_q)
            StIdle: begin
                if (sample_strobe) begin
                    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                        samp_d[i] = voice_samples[i*SAMPLE_W + (SAMPLE_W-SW) +: SW];
                        env_d[i]  = envelopes[i*ENV_W +: ENV_W];
                    end
                    act_d   = voice_active;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                acc_d = acc_q + AccW'(prod);
                idx_d = idx_q + IdxW'(1);
                if (idx_q == IdxW'(NUM_VOICES-1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                r2r_d   = mix;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= StIdle;
            samp_q    <= '0;
            env_q     <= '0;
            act_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            r2r_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            env_q     <= env_d;
            act_q     <= act_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            r2r_q     <= r2r_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign r2r_out   = r2r_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != StIdle);
    assign overrun   = overrun_q;

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Downstream stage of the DDS voice engine. On each audio-rate sample strobe it snapshots the eight per-voice wavetable samples and their envelope levels, then multiplies and accumulates them one voice per clock. The mixed result drives the 8-bit R2R DAC output. It replaces the wide single-cycle sum with a small serial multiply-accumulate.

## Interface
Parameters:
- NUM_VOICES, 8, number of voices mixed; must be 8 (accumulator width fixed at 27 bits)
- SAMPLE_W, 32, width of each wavetable sample; only bits [31:16] are used
- ENV_W, 8, width of each envelope level
- OUT_W, 8, R2R output width

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all logic on posedge
- nreset  in  1  synchronous active-low reset
- sample_strobe  in  1  one-cycle pulse at the audio sample rate
- voice_samples  in  NUM_VOICES*SAMPLE_W  voice i at bits [i*32+31 : i*32]; unsigned
- envelopes  in  NUM_VOICES*ENV_W  voice i at bits [i*8+7 : i*8]; unsigned
- voice_active  in  NUM_VOICES  bit i=1 means voice i contributes
- r2r_out  out  OUT_W  mixed sample, registered
- out_valid  out  1  one-cycle pulse when r2r_out updates
- busy  out  1  high while a mix is in progress (state != IDLE)
- overrun  out  1  sticky; set when a strobe arrives while busy

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On sample_strobe=1, register all three input buses into a snapshot.
  - Clear acc (27 bits) and idx (3 bits), then go to ACCUM.
- ACCUM: each cycle, acc <= acc + (active[idx] ? s[idx] * env[idx] : 0).
  - s[idx] = sample[31:16] (16 bits).
  - The product is 24 bits unsigned.
  - idx increments; after idx=7 is added, go to DONE.
- DONE:
  - r2r_out <= mix(acc) (see Configuration).
  - out_valid <= 1 for this one cycle only.
  - Go to IDLE.
- Arithmetic:
  - Maximum acc is 8*65535*255 = 133,691,400, which fits in 27 bits without wrap.
  - No signed arithmetic; samples are offset-binary.
- Inputs change freely after the strobe edge. Only the snapshot is used.
- A sample_strobe in ACCUM or DONE is ignored: the snapshot and acc are untouched and overrun <= 1.
  - overrun is cleared only by reset.
- A strobe arriving in the same cycle as the DONE→IDLE transition counts as overrun. It is not queued.
- Reset values: r2r_out=0, out_valid=0, busy=0, overrun=0, state=IDLE, acc=0, idx=0.
- Reset mid-mix:
  - The mix is abandoned and no out_valid is produced.
  - r2r_out returns to 0.

## Timing
- Strobe sampled at edge 0.
- ACCUM runs on edges 1..8.
- DONE is entered after edge 8. At edge 9, r2r_out updates and out_valid goes high for the cycle that follows edge 9.
- Latency from strobe edge to r2r_out update: 9 clocks.
- busy is high from after edge 0 until after edge 9.
- A next strobe is accepted at edge 10 at the earliest. Minimum strobe period: NUM_VOICES+2 = 10 clocks.
- The system strobe period is 100 clocks, so overrun indicates a fault.
- r2r_out holds its value between updates.

## Configuration
- MIXER_SATURATE_EN
  - Undefined: mix(acc) = acc[26:19]. This is the divide-by-8 average with headroom for all voices at full scale, and it never clips.
  - Defined: mix(acc) = (acc[26:18] > 255) ? 255 : acc[26:18]. This gives 2x gain with saturation at 255 for typical sparse voicing.
- The macro affects only the DONE-state output mapping. FSM and latency are identical in both builds.

## Test plan
- Reset, then idle 20 cycles -> r2r_out=0, out_valid=0, busy=0, overrun=0.
- All 8 voices active, samples 0xFFFF0000, envelopes 250, one strobe -> at strobe+9: out_valid pulses once and acc=131,070,000. r2r_out=249 (undefined) or 255 (MIXER_SATURATE_EN).
- Only voice 3 active, sample 0x80000000, envelope 128; other voices set to full scale but inactive -> acc=4,194,304; r2r_out=8 (undefined) or 16 (defined).
- Strobe, then change all inputs to 0 at edge 1 -> result equals the snapshot result above. Inputs are not re-sampled.
- Strobes at edges 0, 5 and 9 -> only one out_valid (at edge 9); overrun=1 and stays 1. A strobe at edge 10 is accepted and produces out_valid at edge 19.
- nreset low at edge 4 of a mix, released at edge 6 -> no out_valid, r2r_out=0, busy=0; the next strobe completes normally.
